// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad. It strobes one row low at a time and
//   reads the columns. It debounces presses and releases, and emits one 4-bit
//   key code per accepted press with a single-cycle valid pulse.
//
//   Optional build macro: KEY_REPEAT_EN
//     When defined, a key held for REPEAT_TICKS scan ticks re-pulses key_valid
//     with the same key_code. The pulse repeats for as long as the key stays held.
//     When undefined, key_valid pulses exactly once per accepted press.
//
//   Ports
//     clk        in   system clock
//     rst        in   asynchronous reset, active-high
//     row[3:0]   out  row strobe, active-low, one-hot-low (registered)
//     col[3:0]   in   column sense, active-low, asynchronous to clk
//     key_code   out  last accepted key = row_idx*4 + col_idx (registered)
//     key_valid  out  one-clk pulse when key_code is (re)issued (registered)
//     key_held   out  high while the accepted key remains pressed (registered)
module keypad_scanner #(
  parameter int SCAN_DIV     = 25000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_TICKS = 250
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row,
  input  logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_TARGET = DB_W'(DEBOUNCE_CNT);

  // Reject parameter values the counters cannot honour.
  generate
    if (SCAN_DIV < 1 || DEBOUNCE_CNT < 1 || REPEAT_TICKS < 1) begin : g_param_check
      $error("keypad_scanner: SCAN_DIV, DEBOUNCE_CNT and REPEAT_TICKS must be >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_SCAN     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_ACCEPT   = 3'd2,
    ST_HELD     = 3'd3,
    ST_RELEASE  = 3'd4
  } state_e;

  // Returns {valid, col_idx}. Only a single low column is a valid pattern;
  // no low column and ghosting (several low) both decode as "no key".
  function automatic logic [2:0] decode_col(input logic [3:0] c);
    logic [2:0] r;
    case (c)
      4'b1110: r = {1'b1, 2'd0};
      4'b1101: r = {1'b1, 2'd1};
      4'b1011: r = {1'b1, 2'd2};
      4'b0111: r = {1'b1, 2'd3};
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  // Active-low one-hot strobe for a row index.
  function automatic logic [3:0] row_strobe(input logic [1:0] idx);
    logic [3:0] s;
    case (idx)
      2'd0:    s = 4'b1110;
      2'd1:    s = 4'b1101;
      2'd2:    s = 4'b1011;
      2'd3:    s = 4'b0111;
      default: s = 4'b1110;
    endcase
    return s;
  endfunction

  logic [3:0]       col_meta_q;
  logic [3:0]       col_sync_q;
  logic [DIV_W-1:0] div_q;
  logic             tick_s;
  state_e           state_q;
  logic [1:0]       row_idx_q;
  logic [3:0]       row_q;
  logic [3:0]       cand_q;
  logic [DB_W-1:0]  stable_q;
  logic [DB_W-1:0]  rel_q;
  logic [3:0]       key_code_q;
  logic             key_valid_q;
  logic             key_held_q;

  logic [2:0]       pat_s;
  logic             pat_valid_s;
  logic [1:0]       pat_idx_s;
  logic             all_high_s;
  logic             same_col_s;
  logic [DB_W-1:0]  stable_d;
  logic [DB_W-1:0]  rel_d;
  logic [1:0]       row_idx_d;
  logic [3:0]       row_d;

`ifdef KEY_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_TICKS + 1);
  localparam logic [REP_W-1:0] REP_TARGET = REP_W'(REPEAT_TICKS);
  logic [REP_W-1:0] rep_q;
  logic [REP_W-1:0] rep_d;
`endif

  assign row       = row_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

  // Two-flop synchronizer for the asynchronous column inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta_q <= 4'b1111;
      col_sync_q <= 4'b1111;
    end else begin
      col_meta_q <= col;
      col_sync_q <= col_meta_q;
    end
  end

  // Free-running scan divider; runs in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= {DIV_W{1'b0}};
    end else if (tick_s) begin
      div_q <= {DIV_W{1'b0}};
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  assign tick_s = (div_q == DIV_LAST);

  // Column decode and next-value helpers for the scan FSM.
  always_comb begin
    pat_s       = decode_col(col_sync_q);
    pat_valid_s = pat_s[2];
    pat_idx_s   = pat_s[1:0];
    all_high_s  = (col_sync_q == 4'b1111);
    same_col_s  = pat_valid_s && (pat_idx_s == cand_q[1:0]);
    stable_d    = stable_q + DB_W'(1);
    rel_d       = rel_q + DB_W'(1);
    row_idx_d   = row_idx_q + 2'd1;
    row_d       = row_strobe(row_idx_d);
`ifdef KEY_REPEAT_EN
    rep_d       = rep_q + REP_W'(1);
`endif
  end

  // Scan / debounce / accept / hold / release state machine with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SCAN;
      row_idx_q   <= 2'd0;
      row_q       <= 4'b1110;
      cand_q      <= 4'd0;
      stable_q    <= {DB_W{1'b0}};
      rel_q       <= {DB_W{1'b0}};
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_q       <= {REP_W{1'b0}};
`endif
    end else begin
      key_valid_q <= 1'b0;
      case (state_q)
        ST_SCAN: begin
          if (tick_s) begin
            if (pat_valid_s) begin
              // Row is held from here until the key is rejected or released.
              cand_q   <= {row_idx_q, pat_idx_s};
              stable_q <= DB_W'(1);
              state_q  <= (DEBOUNCE_CNT == 1) ? ST_ACCEPT : ST_DEBOUNCE;
            end else begin
              row_idx_q <= row_idx_d;
              row_q     <= row_d;
            end
          end
        end

        ST_DEBOUNCE: begin
          if (tick_s) begin
            if (same_col_s) begin
              stable_q <= stable_d;
              if (stable_d >= DB_TARGET) begin
                state_q <= ST_ACCEPT;
              end
            end else begin
              cand_q    <= 4'd0;
              stable_q  <= {DB_W{1'b0}};
              row_idx_q <= row_idx_d;
              row_q     <= row_d;
              state_q   <= ST_SCAN;
            end
          end
        end

        ST_ACCEPT: begin
          key_code_q  <= cand_q;
          key_valid_q <= 1'b1;
          key_held_q  <= 1'b1;
          stable_q    <= {DB_W{1'b0}};
          state_q     <= ST_HELD;
`ifdef KEY_REPEAT_EN
          rep_q       <= {REP_W{1'b0}};
`endif
        end

        ST_HELD: begin
          if (tick_s) begin
            if (all_high_s) begin
              if (DEBOUNCE_CNT == 1) begin
                key_held_q <= 1'b0;
                row_idx_q  <= row_idx_d;
                row_q      <= row_d;
                state_q    <= ST_SCAN;
              end else begin
                rel_q   <= DB_W'(1);
                state_q <= ST_RELEASE;
              end
            end else begin
              // Other keys in this row are ignored; other rows are not strobed.
`ifdef KEY_REPEAT_EN
              if (rep_d >= REP_TARGET) begin
                key_valid_q <= 1'b1;
                rep_q       <= {REP_W{1'b0}};
              end else begin
                rep_q <= rep_d;
              end
`endif
            end
          end
        end

        ST_RELEASE: begin
          if (tick_s) begin
            if (all_high_s) begin
              if (rel_d >= DB_TARGET) begin
                key_held_q <= 1'b0;
                rel_q      <= {DB_W{1'b0}};
                row_idx_q  <= row_idx_d;
                row_q      <= row_d;
                state_q    <= ST_SCAN;
              end else begin
                rel_q <= rel_d;
              end
            end else begin
              rel_q   <= {DB_W{1'b0}};
              state_q <= ST_HELD;
`ifdef KEY_REPEAT_EN
              rep_q   <= {REP_W{1'b0}};
`endif
            end
          end
        end

        default: begin
          state_q <= ST_SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed testbench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_TICKS=5).
// A small matrix model turns the pressed-key bitmap into column levels for
// whichever row the DUT strobes. Expected key codes go into a scoreboard queue
// when a press is driven. A negedge monitor records every key_valid pulse, and
// the queue is compared against those records after each scenario.
module tb_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;
  localparam int REPEAT_TICKS = 5;

  logic        clk;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] keys;
  logic [3:0]  rot [0:4];
  logic [3:0]  exp_q [$];
  logic [3:0]  obs_q [$];
  int          rd_idx = 0;
  int          tests  = 0;
  int          failed = 0;

  keypad_scanner #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT),
    .REPEAT_TICKS(REPEAT_TICKS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Matrix model: key r*4+c pulls column c low while row r is strobed.
  always_comb begin
    col = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      if (row[r] == 1'b0) col = col & ~keys[r*4 +: 4];
    end
  end

  // Record every key_valid pulse.
  always @(negedge clk) begin
    if (key_valid === 1'b1) obs_q.push_back(key_code);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare scoreboard entries against recorded pulses, then check no extras.
  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      if (rd_idx < obs_q.size()) begin
        check({tag, "_code"}, 32'(obs_q[rd_idx]), 32'(exp_q[0]));
        rd_idx++;
      end else begin
        check({tag, "_missing"}, 32'(obs_q.size()), 32'(rd_idx + 1));
      end
      void'(exp_q.pop_front());
    end
    check({tag, "_count"}, 32'(obs_q.size()), 32'(rd_idx));
  endtask

  // Release reset and follow one full row rotation at 4 clk per step.
  task automatic release_and_align();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      clk_n(3);
      check("rot_hold", 32'(row), 32'(rot[i]));
      clk_n(1);
      check("rot_step", 32'(row), 32'(rot[i+1]));
    end
  endtask

  initial begin
    rot[0] = 4'b1110; rot[1] = 4'b1101; rot[2] = 4'b1011;
    rot[3] = 4'b0111; rot[4] = 4'b1110;
    rst  = 1'b1;
    keys = 16'h0000;

    // Reset state
    clk_n(3);
    check("rst_row", 32'(row), 32'(4'b1110));
    check("rst_code", 32'(key_code), 32'(4'd0));
    check("rst_valid", 32'(key_valid), 32'(1'b0));
    check("rst_held", 32'(key_held), 32'(1'b0));
    release_and_align();

    // Key 9 (row 2, col 1): accepted on the 3rd matching tick, valid 1 clk later
    keys[9] = 1'b1;
    exp_q.push_back(4'd9);
    clk_n(20);
    check("k9_row_frozen", 32'(row), 32'(4'b1011));
    check("k9_valid_early", 32'(key_valid), 32'(1'b0));
    check("k9_held_early", 32'(key_held), 32'(1'b0));
    clk_n(1);
    check("k9_valid", 32'(key_valid), 32'(1'b1));
    check("k9_code", 32'(key_code), 32'(4'd9));
    check("k9_held", 32'(key_held), 32'(1'b1));
    clk_n(1);
    check("k9_valid_pulse", 32'(key_valid), 32'(1'b0));
`ifdef KEY_REPEAT_EN
    exp_q.push_back(4'd9);
`endif
    clk_n(30);
    check("k9_row_hold", 32'(row), 32'(4'b1011));
    check("k9_held_hold", 32'(key_held), 32'(1'b1));
    check("k9_code_hold", 32'(key_code), 32'(4'd9));
    drain("k9");

    // Asynchronous reset mid-count while a key is held
    clk_n(2);
    rst = 1'b1;
    #1;
    check("mid_rst_row", 32'(row), 32'(4'b1110));
    check("mid_rst_code", 32'(key_code), 32'(4'd0));
    check("mid_rst_valid", 32'(key_valid), 32'(1'b0));
    check("mid_rst_held", 32'(key_held), 32'(1'b0));
    keys = 16'h0000;
    clk_n(2);
    release_and_align();

    // Bounce: two matching ticks only, then scanning resumes at row 3
    keys[9] = 1'b1;
    clk_n(16);
    check("bounce_hold_row", 32'(row), 32'(4'b1011));
    keys[9] = 1'b0;
    clk_n(4);
    check("bounce_row", 32'(row), 32'(4'b0111));
    check("bounce_held", 32'(key_held), 32'(1'b0));
    check("bounce_code", 32'(key_code), 32'(4'd0));
    drain("bounce");

    // Ghost: two columns low in row 0 are ignored
    keys = 16'h0006;
    clk_n(4);
    check("ghost_row0", 32'(row), 32'(4'b1110));
    clk_n(4);
    check("ghost_row1", 32'(row), 32'(4'b1101));
    clk_n(4);
    check("ghost_row2", 32'(row), 32'(4'b1011));
    keys = 16'h0000;
    clk_n(4);
    check("ghost_row3", 32'(row), 32'(4'b0111));
    clk_n(4);
    check("ghost_row4", 32'(row), 32'(4'b1110));
    drain("ghost");

    // Release glitch on key 5: high 2 ticks, low 1, high 3
    keys = 16'h0020;
    exp_q.push_back(4'd5);
    clk_n(16);
    check("k5_row", 32'(row), 32'(4'b1101));
    check("k5_valid_early", 32'(key_valid), 32'(1'b0));
    clk_n(1);
    check("k5_valid", 32'(key_valid), 32'(1'b1));
    check("k5_code", 32'(key_code), 32'(4'd5));
    clk_n(3);
    check("k5_held", 32'(key_held), 32'(1'b1));
    keys = 16'h0000;
    clk_n(8);
    check("glitch_held_a", 32'(key_held), 32'(1'b1));
    keys = 16'h0020;
    clk_n(4);
    check("glitch_held_b", 32'(key_held), 32'(1'b1));
    keys = 16'h0000;
    clk_n(8);
    check("glitch_held_c", 32'(key_held), 32'(1'b1));
    check("glitch_row_c", 32'(row), 32'(4'b1101));
    clk_n(3);
    check("glitch_held_d", 32'(key_held), 32'(1'b1));
    clk_n(1);
    check("glitch_released", 32'(key_held), 32'(1'b0));
    check("glitch_row_adv", 32'(row), 32'(4'b1011));
    check("glitch_code_kept", 32'(key_code), 32'(4'd5));
    drain("glitch");

    // Key 15 held 12 ticks after accept (repeat build adds 2 pulses)
    keys = 16'h8000;
    exp_q.push_back(4'd15);
`ifdef KEY_REPEAT_EN
    exp_q.push_back(4'd15);
    exp_q.push_back(4'd15);
`endif
    clk_n(17);
    check("k15_valid", 32'(key_valid), 32'(1'b1));
    check("k15_code", 32'(key_code), 32'(4'd15));
    check("k15_row", 32'(row), 32'(4'b0111));
    clk_n(47);
    check("k15_held", 32'(key_held), 32'(1'b1));
    check("k15_code_hold", 32'(key_code), 32'(4'd15));
    keys = 16'h0000;
    clk_n(12);
    check("k15_released", 32'(key_held), 32'(1'b0));
    check("k15_row_adv", 32'(row), 32'(4'b1110));
    check("k15_code_kept", 32'(key_code), 32'(4'd15));
    drain("k15");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
